// File: rtl/rotation_pkg.sv
// ---------------------------------------------------------------------------
// rotation_pkg
// Shared types and default sizing for the rotation slicer.
//   slicer_state_t : tracking state machine encoding
//   ROT_RES_DEFAULT: default number of angular slices per revolution
//   THETA_W        : width of the slice index for the default resolution
//   SHIFT          : right shift that turns a period into a slice length
// ---------------------------------------------------------------------------
package rotation_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK,
        STALL
    } slicer_state_t;

    localparam int ROT_RES_DEFAULT = 1024;
    localparam int THETA_W         = $clog2(ROT_RES_DEFAULT);
    localparam int SHIFT           = $clog2(ROT_RES_DEFAULT);

endpackage

// File: rtl/rotation_slicer_debouncer.sv
// ---------------------------------------------------------------------------
// ir_debouncer
// Two-flop synchroniser, stability counter and rising-edge pulse for the raw
// IR beam-break level.
//   clk_in    : system clock
//   rst_in_n  : asynchronous active-low reset
//   raw_in    : raw sensor level, asynchronous to clk_in
//   level_out : debounced level
//   rise_out  : one-cycle pulse on each debounced 0->1 transition
// ---------------------------------------------------------------------------
module ir_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1200
) (
    input  logic clk_in,
    input  logic rst_in_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            level_out  <= 1'b0;
            rise_out   <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_q1  <= raw_in;
            sync_q2  <= sync_q1;
            rise_out <= 1'b0;
            // Any return to the current level restarts the stability window,
            // so only an uninterrupted run of DEBOUNCE_CYCLES flips the level.
            if (sync_q2 == level_out) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_out  <= sync_q2;
                rise_out   <= sync_q2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rotation_slicer.sv
// ---------------------------------------------------------------------------
// rotation_slicer
// Measures the rotor period from the debounced IR index edge and splits each
// revolution into ROTATIONAL_RES equal time slices, publishing the current
// slice index for the frame manager.
//   clk_in      : system clock
//   rst_in_n    : asynchronous active-low reset
//   ir_tripped  : raw IR beam-break level
//   dtheta      : current slice index
//   theta_valid : one-cycle strobe whenever dtheta is (re)written
//   rev_strobe  : one-cycle strobe on each accepted index edge
//   locked      : high while tracking a valid period
//   period      : last accepted revolution period in cycles
// ---------------------------------------------------------------------------
module rotation_slicer
    import rotation_pkg::*;
#(
    parameter int ROTATIONAL_RES  = 1 << SHIFT,
    parameter int PERIOD_W        = 24,
    parameter int DEBOUNCE_CYCLES = 1200,
    parameter int MIN_PERIOD      = 4096,
    parameter int MAX_PERIOD      = (1 << 24) - 1
) (
    input  logic                              clk_in,
    input  logic                              rst_in_n,
    input  logic                              ir_tripped,
    output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    output logic                              theta_valid,
    output logic                              rev_strobe,
    output logic                              locked,
    output logic [PERIOD_W-1:0]               period
);

    localparam int DTHETA_W    = $clog2(ROTATIONAL_RES);
    localparam int SLICE_SHIFT = DTHETA_W;

    slicer_state_t       state;
    logic                edge_acc;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] slice_len;
    logic [PERIOD_W-1:0] slice_cnt;
    logic                cnt_at_max;
    logic                edge_ok;
    logic [PERIOD_W-1:0] meas_period;
    logic [PERIOD_W-1:0] new_slice;

    ir_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_in    (clk_in),
        .rst_in_n  (rst_in_n),
        .raw_in    (ir_tripped),
        .level_out (),
        .rise_out  (edge_acc)
    );

    assign cnt_at_max = (cnt == PERIOD_W'(MAX_PERIOD));
    // Bounce filter used while a period is being measured or tracked.
    assign edge_ok    = edge_acc && (cnt >= PERIOD_W'(MIN_PERIOD));
    // cnt reads 0 in the cycle after an edge, so the elapsed cycle count
    // including the current one is cnt + 1 (clamped when saturated).
    assign meas_period = cnt_at_max ? cnt : cnt + 1'b1;
    assign new_slice   = meas_period >> SLICE_SHIFT;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state       <= IDLE;
            cnt         <= '0;
            slice_len   <= '0;
            slice_cnt   <= '0;
            period      <= '0;
            dtheta      <= '0;
            theta_valid <= 1'b0;
            rev_strobe  <= 1'b0;
            locked      <= 1'b0;
        end else begin
            theta_valid <= 1'b0;
            rev_strobe  <= 1'b0;
            if (!cnt_at_max) cnt <= cnt + 1'b1;

            unique case (state)
                IDLE, STALL: begin
                    // First edge after idle or stall only starts a measurement.
                    if (edge_acc) begin
                        cnt        <= '0;
                        rev_strobe <= 1'b1;
                        state      <= ACQUIRE;
                    end
                end
                ACQUIRE, TRACK: begin
                    // An edge wins over both stall detection and slice expiry.
                    if (edge_ok) begin
                        cnt         <= '0;
                        period      <= meas_period;
                        slice_len   <= new_slice;
                        slice_cnt   <= new_slice - 1'b1;
                        dtheta      <= '0;
                        theta_valid <= 1'b1;
                        rev_strobe  <= 1'b1;
                        locked      <= 1'b1;
                        state       <= TRACK;
                    end else if (cnt_at_max) begin
                        dtheta      <= '0;
                        theta_valid <= 1'b1;
                        locked      <= 1'b0;
                        state       <= STALL;
                    end else if (state == TRACK) begin
                        if (slice_cnt == '0) begin
                            slice_cnt <= slice_len - 1'b1;
                            // The last slice holds and absorbs any remainder.
                            if (dtheta != DTHETA_W'(ROTATIONAL_RES - 1)) begin
                                dtheta      <= dtheta + 1'b1;
                                theta_valid <= 1'b1;
                            end
                        end else begin
                            slice_cnt <= slice_cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rotation_slicer.sv
module tb_rotation_slicer;

    localparam int RES   = 16;
    localparam int SHIFT = 4;
    localparam int PW    = 12;
    localparam int DEB   = 8;
    localparam int MINP  = 64;
    localparam int MAXP  = 1000;
    localparam int HIGHW = 12;   // raw pulse width, comfortably above DEB
    localparam int LAT   = DEB + 3; // raw rise -> outputs updated

    logic            clk_in = 1'b0;
    logic            rst_in_n = 1'b0;
    logic            ir_tripped = 1'b0;
    logic [SHIFT-1:0] dtheta;
    logic            theta_valid;
    logic            rev_strobe;
    logic            locked;
    logic [PW-1:0]   period;

    rotation_slicer #(
        .ROTATIONAL_RES  (RES),
        .PERIOD_W        (PW),
        .DEBOUNCE_CYCLES (DEB),
        .MIN_PERIOD      (MINP),
        .MAX_PERIOD      (MAXP)
    ) dut (
        .clk_in      (clk_in),
        .rst_in_n    (rst_in_n),
        .ir_tripped  (ir_tripped),
        .dtheta      (dtheta),
        .theta_valid (theta_valid),
        .rev_strobe  (rev_strobe),
        .locked      (locked),
        .period      (period)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int t; int dth; int tv; int rs; int lk; int per;
    } ev_t;
    ev_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // ---------------- reference model (time-based) ----------------
    // 0 idle, 1 acquire, 2 track, 3 stall
    int m_state = 0;
    int m_last_acc = 0;
    int m_period = 0;
    int m_len = 0;
    int m_gen_upto = 0;

    task automatic push_ev(input int t, input int dth, input int tv,
                           input int rs, input int lk, input int per);
        ev_t e;
        e.t = t; e.dth = dth; e.tv = tv; e.rs = rs; e.lk = lk; e.per = per;
        exp_q.push_back(e);
    endtask

    // Emit slice and stall events falling in [m_gen_upto, t).
    task automatic advance(input int t);
        int stall_t;
        int ts;
        if (m_state == 1 || m_state == 2) begin
            stall_t = m_last_acc + MAXP + 1;
            if (m_state == 2) begin
                for (int j = 1; j < RES; j++) begin
                    ts = m_last_acc + j * m_len;
                    if (ts >= m_gen_upto && ts < t && ts < stall_t)
                        push_ev(ts, j, 1, 0, 1, m_period);
                end
            end
            if (stall_t >= m_gen_upto && stall_t < t) begin
                push_ev(stall_t, 0, 1, 0, 0, m_period);
                m_state = 3;
            end
        end
        m_gen_upto = t;
    endtask

    task automatic model_edge(input int acc);
        int elapsed;
        if (m_state == 0 || m_state == 3) begin
            push_ev(acc, 0, 0, 1, 0, m_period);
            m_state = 1;
            m_last_acc = acc;
        end else begin
            elapsed = acc - m_last_acc;          // cycles between accepted edges
            if (elapsed - 1 >= MINP) begin
                m_period = (elapsed > MAXP) ? MAXP : elapsed;
                m_len = m_period / RES;
                push_ev(acc, 0, 1, 1, 1, m_period);
                m_state = 2;
                m_last_acc = acc;
            end
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk_in);
    endtask

    task automatic wait_model(input int t);
        advance(t);
        wait_cyc(t);
    endtask

    // Raw rise applied just after posedge k.
    task automatic issue_rise(input int k);
        advance(k + LAT);
        model_edge(k + LAT);
        wait_cyc(k);
        ir_tripped = 1'b1;
        repeat (HIGHW) @(negedge clk_in);
        ir_tripped = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int h_dth;
        int h_lk;
        int h_per;
        ev_t e;
        h_dth = 0; h_lk = 0; h_per = 0;
        forever begin
            @(negedge clk_in);
            if (!rst_in_n) begin
                h_dth = 0; h_lk = 0; h_per = 0;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                    e = exp_q.pop_front();
                    chk("missed_event_cycle", cyc, e.t);
                end
                if (theta_valid || rev_strobe) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe_tv", int'(theta_valid), 0);
                        chk("unexpected_strobe_rs", int'(rev_strobe), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_cycle", cyc, e.t);
                        chk("event_theta_valid", int'(theta_valid), e.tv);
                        chk("event_rev_strobe", int'(rev_strobe), e.rs);
                        h_dth = e.dth; h_lk = e.lk; h_per = e.per;
                    end
                end
                chk("dtheta", int'(dtheta), h_dth);
                chk("locked", int'(locked), h_lk);
                chk("period", int'(period), h_per);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int p;
        int b;
        int rt;

        rst_in_n = 1'b0;
        ir_tripped = 1'b0;
        repeat (10) @(posedge clk_in);
        #1;
        chk("rst_dtheta", int'(dtheta), 0);
        chk("rst_theta_valid", int'(theta_valid), 0);
        chk("rst_rev_strobe", int'(rev_strobe), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_period", int'(period), 0);
        @(negedge clk_in);
        rst_in_n = 1'b1;
        m_gen_upto = cyc;

        // Idle with a quiet sensor: the monitor flags any strobe.
        wait_cyc(cyc + 2000);

        // Glitches shorter than the debounce window are rejected.
        for (int i = 0; i < 4; i++) begin
            ir_tripped = 1'b1;
            repeat ($urandom_range(1, DEB - 2)) @(negedge clk_in);
            ir_tripped = 1'b0;
            repeat (40) @(negedge clk_in);
        end
        chk("glitch_no_lock", int'(locked), 0);

        // Acquire and lock on an exact multiple, then a full wrap.
        k = cyc + 5;
        issue_rise(k);
        k += 160; issue_rise(k);
        k += 160; issue_rise(k);
        // Remainder: last slice holds RES-1 for the extra cycles.
        k += 167; issue_rise(k);
        k += 167; issue_rise(k);

        // Random periods, some with an early bounce edge.
        for (int i = 0; i < 12; i++) begin
            p = $urandom_range(100, 400);
            if ($urandom_range(0, 1) == 1) begin
                b = $urandom_range(26, 40);
                issue_rise(k + b);
            end
            k += p;
            issue_rise(k);
        end

        // Stall: no more edges.
        wait_model(m_last_acc + MAXP + 40);
        chk("stall_locked", int'(locked), 0);
        chk("stall_dtheta", int'(dtheta), 0);

        // Recover: first edge re-acquires, second locks.
        k = cyc + 5;
        issue_rise(k);
        k += 320; issue_rise(k);
        k += 320; issue_rise(k);

        // Asynchronous reset in mid-revolution at half scale.
        rt = m_last_acc + (RES / 2) * m_len + 1;
        wait_model(rt);
        chk("pre_reset_dtheta", int'(dtheta), RES / 2);
        #2;
        rst_in_n = 1'b0;
        #1;
        chk("async_rst_dtheta", int'(dtheta), 0);
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_period", int'(period), 0);
        chk("async_rst_pending", exp_q.size(), 0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in_n = 1'b1;
        m_state = 0; m_period = 0; m_len = 0; m_gen_upto = cyc;

        // Re-acquire from idle after reset.
        k = cyc + 5;
        issue_rise(k);
        k += 240; issue_rise(k);
        wait_model(m_last_acc + 260);
        chk("final_locked", int'(locked), 1);
        chk("final_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
